// File: rtl/axi_excl_sram_slave.sv
// Single-beat AXI4 slave in front of a word-addressed SRAM, with a one-entry
// exclusive-access monitor for LR/SC style traffic.
module axi_excl_sram_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ID_W        = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_awaddr,
    input  logic [ID_W-1:0] s_awid,
    input  logic [7:0]      s_awlen,
    input  logic            s_awlock,
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    output logic            s_bvalid,
    input  logic            s_bready,
    output logic [1:0]      s_bresp,
    output logic [ID_W-1:0] s_bid,
    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [31:0]     s_araddr,
    input  logic [ID_W-1:0] s_arid,
    input  logic [7:0]      s_arlen,
    input  logic            s_arlock,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [31:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic [ID_W-1:0] s_rid,
    output logic            s_rlast
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L     = DEPTH_WORDS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_COLLECT, WR_RESP, RD_RESP} state_t;
    state_t state, state_nxt;

    // Bursts are not supported: any len != 0 is answered as a single-beat error.
    function automatic logic addr_ok(input logic [31:0] addr, input logic [7:0] len);
        return (((addr - BASE_ADDR) >> 2) < DEPTH_L) && (len == 8'd0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0]      mem [DEPTH_WORDS];
    logic             aw_got, w_got;
    logic             aw_ok, aw_lock;
    logic [IDX_W-1:0] aw_idx;
    logic [ID_W-1:0]  aw_id;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             resv_valid;
    logic [IDX_W-1:0] resv_idx;
    logic [ID_W-1:0]  resv_id;
    logic [1:0]       bresp, rresp;
    logic [ID_W-1:0]  bid, rid;
    logic [31:0]      rdata;

    logic             aw_hs, w_hs, ar_hs, wr_exec, ex_ok, wr_perm, ar_ok;
    logic             cur_ok, cur_lock;
    logic [IDX_W-1:0] cur_idx, ar_idx;
    logic [ID_W-1:0]  cur_id;
    logic [31:0]      cur_data;
    logic [3:0]       cur_strb;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;

    // The half arriving on this edge is taken straight from the bus, the other from its latch.
    assign cur_ok   = aw_hs ? addr_ok(s_awaddr, s_awlen) : aw_ok;
    assign cur_lock = aw_hs ? s_awlock : aw_lock;
    assign cur_idx  = aw_hs ? addr_idx(s_awaddr) : aw_idx;
    assign cur_id   = aw_hs ? s_awid : aw_id;
    assign cur_data = w_hs ? s_wdata : w_data;
    assign cur_strb = w_hs ? s_wstrb : w_strb;

    assign wr_exec = (aw_got | aw_hs) & (w_got | w_hs) & (aw_hs | w_hs);
    assign ex_ok   = cur_lock & cur_ok & resv_valid & (resv_idx == cur_idx) & (resv_id == cur_id);
    assign wr_perm = cur_ok & (~cur_lock | ex_ok);
    assign ar_ok   = addr_ok(s_araddr, s_arlen);
    assign ar_idx  = addr_idx(s_araddr);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WR_COLLECT: begin
                if (wr_exec)                               state_nxt = WR_RESP;
                else if (aw_got | aw_hs | w_got | w_hs)    state_nxt = WR_COLLECT;
                else if (ar_hs)                            state_nxt = RD_RESP;
            end
            WR_RESP: if (s_bready) state_nxt = IDLE;
            RD_RESP: if (s_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_arready = 1'b0;
        s_bvalid  = 1'b0;
        s_rvalid  = 1'b0;
        if (!rst) begin
            s_awready = ((state == IDLE) || (state == WR_COLLECT)) && !aw_got;
            s_wready  = ((state == IDLE) || (state == WR_COLLECT)) && !w_got;
            s_arready = (state == IDLE) && !s_awvalid && !s_wvalid;
            s_bvalid  = (state == WR_RESP);
            s_rvalid  = (state == RD_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            resv_valid <= 1'b0;
            bresp      <= RESP_OKAY;
            bid        <= '0;
            rresp      <= RESP_OKAY;
            rid        <= '0;
            rdata      <= '0;
        end else begin
            if (wr_exec) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bid    <= cur_id;
                bresp  <= !cur_ok ? RESP_SLVERR : (ex_ok ? RESP_EXOKAY : RESP_OKAY);
                // A successful SC consumes the reservation; a plain store to it breaks it.
                if (ex_ok || (cur_ok && !cur_lock && (resv_idx == cur_idx)))
                    resv_valid <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (ar_hs) begin
                rid   <= s_arid;
                rresp <= !ar_ok ? RESP_SLVERR : (s_arlock ? RESP_EXOKAY : RESP_OKAY);
                rdata <= ar_ok ? mem[ar_idx] : 32'h0;
                if (ar_ok && s_arlock) begin
                    resv_valid <= 1'b1;
                    resv_idx   <= ar_idx;
                    resv_id    <= s_arid;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_ok   <= addr_ok(s_awaddr, s_awlen);
            aw_lock <= s_awlock;
            aw_idx  <= addr_idx(s_awaddr);
            aw_id   <= s_awid;
        end
        if (w_hs) begin
            w_data <= s_wdata;
            w_strb <= s_wstrb;
        end
        if (wr_exec && wr_perm) begin
            for (int b = 0; b < 4; b++)
                if (cur_strb[b]) mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
        end
    end

    assign s_bresp = bresp;
    assign s_bid   = bid;
    assign s_rresp = rresp;
    assign s_rid   = rid;
    assign s_rdata = rdata;
    assign s_rlast = 1'b1;
endmodule

// File: tb/tb_axi_excl_sram_slave.sv
// Scoreboard bench for axi_excl_sram_slave: expected responses are queued as
// each request is driven and checked when the slave presents the response.
module tb_axi_excl_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, s_awlock;
    logic [31:0] s_awaddr;
    logic [0:0]  s_awid;
    logic [7:0]  s_awlen;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic [0:0]  s_bid;
    logic        s_arvalid, s_arready, s_arlock;
    logic [31:0] s_araddr;
    logic [0:0]  s_arid;
    logic [7:0]  s_arlen;
    logic        s_rvalid, s_rready, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [0:0]  s_rid;

    typedef struct { logic [1:0] resp; logic [0:0] id; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic [0:0] id; } r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    axi_excl_sram_slave dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awlock(s_awlock),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arlock(s_arlock),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast)
    );

    always #5 clk = ~clk;

    task automatic expect_b(input logic [1:0] resp, input logic [0:0] id);
        b_exp_t e;
        e.resp = resp;
        e.id   = id;
        b_q.push_back(e);
    endtask

    // Drives AW and W together and checks bvalid appears on the cycle after acceptance.
    task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [0:0] id, input logic lock, input logic [7:0] len);
        int n;
        logic a_hs, w_hs, a_done, w_done;
        s_awaddr = addr; s_awid = id; s_awlock = lock; s_awlen = len;
        s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        a_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(a_done && w_done) && n < 20) begin
            @(negedge clk);
            a_hs = s_awvalid & s_awready;
            w_hs = s_wvalid & s_wready;
            @(posedge clk); #1;
            if (a_hs) begin a_done = 1'b1; s_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; s_wvalid = 1'b0; end
            n++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_checks++;
        if (!(a_done && w_done)) begin
            n_fail++;
            $display("FAIL write_accept addr=%h: aw_done=%b w_done=%b, required both within 20 cycles", addr, a_done, w_done);
        end else if (s_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bvalid_latency addr=%h: bvalid=%b, required 1", addr, s_bvalid);
        end
    endtask

    task automatic collect_b();
        b_exp_t e;
        n_checks++;
        if (b_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_scoreboard: response with empty queue");
            return;
        end
        e = b_q.pop_front();
        if (s_bvalid !== 1'b1 || s_bresp !== e.resp || s_bid !== e.id) begin
            n_fail++;
            $display("FAIL b_resp: bvalid=%b bresp=%b bid=%b, required 1 %b %b", s_bvalid, s_bresp, s_bid, e.resp, e.id);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        n_checks++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_release: bvalid=%b awready=%b, required 0 1", s_bvalid, s_awready);
        end
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [0:0] id, input logic lock, input logic [7:0] len, input logic [1:0] resp);
        expect_b(resp, id);
        send_write(addr, data, strb, id, lock, len);
        collect_b();
    endtask

    task automatic read_op(input logic [31:0] addr, input logic [0:0] id, input logic lock, input logic [7:0] len,
                           input logic [31:0] data, input logic [1:0] resp, input int hold);
        r_exp_t e;
        int n;
        logic hs, done;
        logic [31:0] held;
        e.data = data; e.resp = resp; e.id = id;
        r_q.push_back(e);
        s_araddr = addr; s_arid = id; s_arlock = lock; s_arlen = len; s_arvalid = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            hs = s_arvalid & s_arready;
            @(posedge clk); #1;
            if (hs) done = 1'b1;
            n++;
        end
        s_arvalid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL read_accept addr=%h: no arready within 20 cycles", addr);
            void'(r_q.pop_front());
            return;
        end
        if (s_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rvalid_latency addr=%h: rvalid=%b, required 1", addr, s_rvalid);
        end
        held = s_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== held) begin
                n_fail++;
                $display("FAIL r_hold cycle %0d: rvalid=%b rdata=%h, required 1 %h", i, s_rvalid, s_rdata, held);
            end
        end
        e = r_q.pop_front();
        n_checks++;
        if (s_rdata !== e.data || s_rresp !== e.resp || s_rid !== e.id || s_rlast !== 1'b1) begin
            n_fail++;
            $display("FAIL r_resp addr=%h: rdata=%h rresp=%b rid=%b rlast=%b, required %h %b %b 1",
                     addr, s_rdata, s_rresp, s_rid, s_rlast, e.data, e.resp, e.id);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        n_checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL r_release: rvalid=%b arready=%b, required 0 1", s_rvalid, s_arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awlock = 0; s_wdata = 0; s_wstrb = 0;
        s_araddr = 0; s_arid = 0; s_arlen = 0; s_arlock = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: aw/w/ar ready, b/r valid = %b, required 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_idle: aw/w/ar ready, b/r valid = %b, required 11100",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        n_checks++;
        if (s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'h0 || s_bid !== 1'b0 || s_rid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: bresp=%b rresp=%b rdata=%h bid=%b rid=%b, required all 0",
                     s_bresp, s_rresp, s_rdata, s_bid, s_rid);
        end
    endtask

    task automatic test_write_read();
        write_op(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h10, 1'b0, 1'b0, 8'd0, 32'hDEADBEEF, 2'b00, 0);
        write_op(32'h14, 32'hA5A5_0001, 4'hF, 1'b1, 1'b0, 8'd0, 2'b00);
        read_op(32'h14, 1'b1, 1'b0, 8'd0, 32'hA5A5_0001, 2'b00, 0);
    endtask

    task automatic test_exclusive();
        write_op(32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h20, 1'b0, 1'b1, 8'd0, 32'h0, 2'b01, 0);
        write_op(32'h20, 32'h5, 4'hF, 1'b0, 1'b1, 8'd0, 2'b01);
        read_op(32'h20, 1'b0, 1'b0, 8'd0, 32'h5, 2'b00, 0);
        write_op(32'h20, 32'h6, 4'hF, 1'b0, 1'b1, 8'd0, 2'b00);
        read_op(32'h20, 1'b0, 1'b0, 8'd0, 32'h5, 2'b00, 0);
        // ID and address must both match the reservation
        write_op(32'h70, 32'h1, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h70, 1'b1, 1'b1, 8'd0, 32'h1, 2'b01, 0);
        write_op(32'h70, 32'h2, 4'hF, 1'b0, 1'b1, 8'd0, 2'b00);
        write_op(32'h74, 32'h2, 4'hF, 1'b1, 1'b1, 8'd0, 2'b00);
        write_op(32'h70, 32'h3, 4'hF, 1'b1, 1'b1, 8'd0, 2'b01);
        read_op(32'h70, 1'b0, 1'b0, 8'd0, 32'h3, 2'b00, 0);
    endtask

    task automatic test_excl_broken();
        write_op(32'h30, 32'h1, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h30, 1'b0, 1'b1, 8'd0, 32'h1, 2'b01, 0);
        write_op(32'h30, 32'h7, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        write_op(32'h30, 32'h9, 4'hF, 1'b0, 1'b1, 8'd0, 2'b00);
        read_op(32'h30, 1'b0, 1'b0, 8'd0, 32'h7, 2'b00, 0);
    endtask

    task automatic test_split();
        logic hs;
        write_op(32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        expect_b(2'b00, 1'b1);
        s_wdata = 32'h0000AB00; s_wstrb = 4'b0010; s_wvalid = 1'b1;
        @(negedge clk);
        hs = s_wvalid & s_wready;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        n_checks++;
        if (hs !== 1'b1) begin
            n_fail++;
            $display("FAIL split_w_accept: w handshake=%b, required 1", hs);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0 || s_arready !== 1'b0) begin
                n_fail++;
                $display("FAIL split_collect cycle %0d: wready=%b awready=%b bvalid=%b arready=%b, required 0 1 0 0",
                         i, s_wready, s_awready, s_bvalid, s_arready);
            end
            @(posedge clk); #1;
        end
        s_awaddr = 32'h40; s_awid = 1'b1; s_awlock = 1'b0; s_awlen = 8'd0; s_awvalid = 1'b1;
        @(negedge clk);
        hs = s_awvalid & s_awready;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        n_checks++;
        if (hs !== 1'b1 || s_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL split_aw_bvalid: aw handshake=%b bvalid=%b, required 1 1", hs, s_bvalid);
        end
        collect_b();
        read_op(32'h40, 1'b0, 1'b0, 8'd0, 32'h0000AB00, 2'b00, 0);
        write_op(32'h50, 32'h11111111, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        write_op(32'h50, 32'h00AA0000, 4'b0100, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h50, 1'b0, 1'b0, 8'd0, 32'h11AA1111, 2'b00, 0);
    endtask

    task automatic test_priority();
        s_araddr = 32'h58; s_arid = 1'b0; s_arlock = 1'b0; s_arlen = 8'd0; s_arvalid = 1'b1;
        s_awaddr = 32'h58; s_awid = 1'b0; s_awlock = 1'b0; s_awlen = 8'd0; s_awvalid = 1'b1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        expect_b(2'b00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (s_arready !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_ready: arready=%b awready=%b wready=%b, required 0 1 1", s_arready, s_awready, s_wready);
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_checks++;
        if (s_bvalid !== 1'b1 || s_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_write_first: bvalid=%b rvalid=%b, required 1 0", s_bvalid, s_rvalid);
        end
        collect_b();
        read_op(32'h58, 1'b0, 1'b0, 8'd0, 32'hCAFEF00D, 2'b00, 4);
    endtask

    task automatic test_errors();
        read_op(32'h0000_1000, 1'b1, 1'b0, 8'd0, 32'h0, 2'b10, 0);
        read_op(32'h10, 1'b0, 1'b0, 8'd3, 32'h0, 2'b10, 0);
        write_op(32'h0000_1000, 32'h1234, 4'hF, 1'b1, 1'b0, 8'd0, 2'b10);
        write_op(32'h10, 32'h5555_5555, 4'hF, 1'b0, 1'b0, 8'd2, 2'b10);
        read_op(32'h10, 1'b0, 1'b0, 8'd0, 32'hDEADBEEF, 2'b00, 0);
    endtask

    task automatic test_reset_mid();
        write_op(32'h60, 32'h12345678, 4'hF, 1'b0, 1'b0, 8'd0, 2'b00);
        read_op(32'h60, 1'b0, 1'b1, 8'd0, 32'h12345678, 2'b01, 0);
        send_write(32'h64, 32'hAAAA5555, 4'hF, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b0 || s_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: bvalid=%b awready=%b arready=%b, required 0 0 0", s_bvalid, s_awready, s_arready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_arready !== 1'b1 || s_bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_idle: bvalid=%b awready=%b arready=%b bresp=%b, required 0 1 1 00",
                     s_bvalid, s_awready, s_arready, s_bresp);
        end
        write_op(32'h60, 32'hBBBB, 4'hF, 1'b0, 1'b1, 8'd0, 2'b00);
        read_op(32'h60, 1'b0, 1'b0, 8'd0, 32'h12345678, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_exclusive();
        test_excl_broken();
        test_split();
        test_priority();
        test_errors();
        test_reset_mid();
        n_checks++;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d b and %0d r left, required 0 0", b_q.size(), r_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
